// File: rtl/mux_console.sv
// Memory-mapped serial console: a status/data register pair on the CPU bus,
// a one-byte transmit holding register and a one-byte receive buffer with error flags.
module mux_console #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  input  logic        readEnBus,
  output logic [7:0]  dataInBus,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [15:0]      DATA_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic       sel_status, sel_data, data_read, err_clear;
  logic       tx_empty, tx_idle, rx_rdy, fe, ovr;
  logic [7:0] rx_data, status;

  assign sel_status = (addressBus == BASE_ADDR);
  assign sel_data   = (addressBus == DATA_ADDR);
  assign data_read  = readEnBus && sel_data;
  assign err_clear  = data_read || (writeEnBus && sel_status && dataOutBus[7]);

  assign status    = {3'b000, tx_idle, ovr, fe, tx_empty, rx_rdy};
  assign dataInBus = sel_status ? status : (sel_data ? rx_data : 8'h00);
  assign irq       = rx_rdy;

  // Transmitter
  state_t           tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_hold, tx_shift;
  logic             tx_tick, tx_write, tx_load, tx_shift_en;

  assign tx_tick  = (tx_cnt == CNT_LAST);
  assign tx_write = writeEnBus && sel_data && tx_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty) tx_next = S_START;
      S_START: if (tx_tick) tx_next = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_tick) tx_next = tx_empty ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  // txd decodes straight from state so an async reset forces the line high at once
  always_comb begin
    txd         = 1'b1;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    case (tx_state)
      S_IDLE:  tx_load = !tx_empty;
      S_START: txd = 1'b0;
      S_DATA:  begin txd = tx_shift[0]; tx_shift_en = tx_tick; end
      S_STOP:  tx_load = tx_tick && !tx_empty;
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_empty <= 1'b1;
      tx_idle  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      if (tx_load)       tx_empty <= 1'b1;
      else if (tx_write) tx_empty <= 1'b0;
      if (tx_load)                                  tx_idle <= 1'b0;
      else if (tx_state == S_STOP && tx_tick)       tx_idle <= 1'b1;
      if (tx_load || tx_tick || tx_state == S_IDLE) tx_cnt <= '0;
      else                                          tx_cnt <= tx_cnt + CNT_ONE;
      if (tx_state == S_START) tx_bit <= '0;
      else if (tx_shift_en)    tx_bit <= tx_bit + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_write) tx_hold <= dataOutBus;
    if (tx_load)          tx_shift <= tx_hold;
    else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // Receiver
  logic             rx_meta, rx_line;
  state_t           rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick, rx_mid, rx_sample, rx_done, rx_cnt_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) {rx_meta, rx_line} <= 2'b11;
    else       {rx_meta, rx_line} <= {rxd, rx_meta};
  end

  assign rx_tick = (rx_cnt == CNT_LAST);
  assign rx_mid  = (rx_cnt == CNT_MID);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= S_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_line) rx_next = S_START;
      S_START: if (rx_mid) rx_next = rx_line ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_sample  = 1'b0;
    rx_done    = 1'b0;
    rx_cnt_clr = 1'b1;
    case (rx_state)
      S_IDLE:  rx_cnt_clr = 1'b1;
      S_START: rx_cnt_clr = rx_mid;
      S_DATA:  begin rx_sample = rx_tick; rx_cnt_clr = rx_tick; end
      S_STOP:  begin rx_done = rx_tick; rx_cnt_clr = rx_tick; end
      default: rx_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else begin
      if (rx_cnt_clr) rx_cnt <= '0;
      else            rx_cnt <= rx_cnt + CNT_ONE;
      if (rx_state == S_START) rx_bit <= '0;
      else if (rx_sample)      rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_sample) rx_shift <= {rx_line, rx_shift[7:1]};
  end

  // A byte completing on the same edge as a data read wins over the read's clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_rdy  <= 1'b0;
      fe      <= 1'b0;
      ovr     <= 1'b0;
      rx_data <= 8'h00;
    end else if (rx_done) begin
      rx_rdy  <= 1'b1;
      rx_data <= rx_shift;
      fe      <= (fe & ~err_clear) | ~rx_line;
      ovr     <= (ovr & ~err_clear) | (rx_rdy & ~data_read);
    end else begin
      if (data_read) rx_rdy <= 1'b0;
      if (err_clear) begin
        fe  <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_console.sv
// Bench for mux_console: transmit waveforms, receive flags and priority cases,
// and randomized concurrent TX/RX traffic against an event-level register model.
module tb_mux_console;
  localparam int          CPB = 16;
  localparam logic [15:0] ST  = 16'hF200;
  localparam logic [15:0] DT  = 16'hF201;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addressBus;
  logic [7:0]  dataOutBus;
  logic        writeEnBus;
  logic        readEnBus;
  logic [7:0]  dataInBus;
  logic        rxd;
  logic        txd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic       m_rdy, m_fe, m_ovr;
  logic [7:0] m_data;
  logic [7:0] s, s2;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_status;
    int         action;
    logic [7:0] exp_after;
  } rx_vec_t;
  rx_vec_t tbl [8];

  mux_console #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .addressBus(addressBus), .dataOutBus(dataOutBus),
    .writeEnBus(writeEnBus), .readEnBus(readEnBus), .dataInBus(dataInBus),
    .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  function automatic logic [7:0] model_status();
    return {3'b000, 1'b1, m_ovr, m_fe, 1'b1, m_rdy};
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop);
    m_ovr  = m_ovr | m_rdy;
    m_fe   = m_fe | ~stop;
    m_rdy  = 1'b1;
    m_data = b;
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    addressBus = a;
    #1;
    d = dataInBus;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addressBus = a; dataOutBus = d; writeEnBus = 1'b1;
    @(negedge clock);
    writeEnBus = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    addressBus = a; readEnBus = 1'b1;
    #1 d = dataInBus;
    @(negedge clock);
    readEnBus = 1'b0;
  endtask

  // Compares txd once per clock for one whole frame, starting at the current negedge
  task automatic tx_expect(input logic [7:0] b);
    for (int i = 0; i < 10 * CPB; i++) begin
      chk($sformatf("txd_%02h_bit%0d", b, i / CPB), txd, frame_bit(b, i / CPB));
      @(negedge clock);
    end
  endtask

  task automatic tx_expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("txd_idle", txd, 1'b1);
      @(negedge clock);
    end
  endtask

  task automatic tx_send_check(input logic [7:0] b);
    logic [7:0] st;
    bus_write(DT, b);
    peek(ST, st);
    chk("tx_empty_after_write", st[1], 1'b0);
    @(negedge clock);
    tx_expect(b);
    chk("txd_after_frame", txd, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      rxd = (i == 0) ? 1'b0 : ((i == 9) ? stop : b[i-1]);
      repeat (CPB - 1) @(negedge clock);
    end
    @(negedge clock);
    rxd = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic strobe_at_stop_sample();
    @(negedge clock);
    repeat (155) @(negedge clock);
    addressBus = DT; readEnBus = 1'b1;
    @(negedge clock);
    readEnBus = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h3C, 1'b1, 8'h13, 1, 8'h12};
    tbl[1] = '{8'h00, 1'b1, 8'h13, 1, 8'h12};
    tbl[2] = '{8'hFF, 1'b1, 8'h13, 1, 8'h12};
    tbl[3] = '{8'h5A, 1'b0, 8'h17, 1, 8'h12};
    tbl[4] = '{8'h81, 1'b1, 8'h13, 0, 8'h13};
    tbl[5] = '{8'h7E, 1'b0, 8'h1F, 2, 8'h13};
    tbl[6] = '{8'hC3, 1'b1, 8'h1B, 3, 8'h1B};
    tbl[7] = '{8'h96, 1'b1, 8'h1B, 1, 8'h12};

    reset = 1'b1; addressBus = ST; dataOutBus = 8'h00;
    writeEnBus = 1'b0; readEnBus = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clock);
    peek(ST, s);
    chk("status_in_reset", s, 8'h12);
    @(negedge clock);
    reset = 1'b0;

    // Post-reset register view
    @(negedge clock);
    peek(ST, s);
    chk("status_after_reset", s, 8'h12);
    chk("txd_after_reset", txd, 1'b1);
    chk("irq_after_reset", irq, 1'b0);
    peek(DT, s);
    chk("rx_data_after_reset", s, 8'h00);
    peek(16'h1234, s);
    chk("unmapped_read", s, 8'h00);

    // Single byte A5
    bus_write(DT, 8'hA5);
    peek(ST, s);
    chk("status_after_write", s, 8'h10);
    @(negedge clock);
    peek(ST, s);
    chk("status_tx_started", s, 8'h02);
    tx_expect(8'hA5);
    peek(ST, s);
    chk("status_tx_done", s, 8'h12);

    // 41 then 42 contiguous, 43 dropped
    fork
      begin
        bus_write(DT, 8'h41);
        bus_write(DT, 8'h42);
        peek(ST, s2);
        chk("tx_full_before_43", s2[1], 1'b0);
        bus_write(DT, 8'h43);
      end
      begin
        repeat (3) @(negedge clock);
        tx_expect(8'h41);
        tx_expect(8'h42);
        tx_expect_idle(3 * CPB);
      end
    join
    peek(ST, s);
    chk("status_after_pair", s, 8'h12);

    // Receive vector table
    for (int i = 0; i < 8; i++) begin
      send_rx(tbl[i].data, tbl[i].stop);
      peek(ST, s);
      chk($sformatf("rx%0d_status", i), s, tbl[i].exp_status);
      chk($sformatf("rx%0d_irq", i), irq, tbl[i].exp_status[0]);
      peek(DT, s);
      chk($sformatf("rx%0d_data", i), s, tbl[i].data);
      case (tbl[i].action)
        1: bus_read(DT, s);
        2: bus_write(ST, 8'h80);
        3: bus_write(ST, 8'h7F);
        default: ;
      endcase
      peek(ST, s);
      chk($sformatf("rx%0d_after", i), s, tbl[i].exp_after);
    end

    // Read strobe on the same edge as a completing byte
    send_rx(8'h11, 1'b1);
    peek(ST, s);
    chk("prio_setup_status", s, 8'h13);
    fork
      send_rx(8'h22, 1'b1);
      strobe_at_stop_sample();
    join
    peek(ST, s);
    chk("prio_good_status", s, 8'h13);
    peek(DT, s);
    chk("prio_good_data", s, 8'h22);
    fork
      send_rx(8'h33, 1'b0);
      strobe_at_stop_sample();
    join
    peek(ST, s);
    chk("prio_fe_status", s, 8'h17);
    peek(DT, s);
    chk("prio_fe_data", s, 8'h33);
    bus_read(DT, s);
    peek(ST, s);
    chk("prio_cleared", s, 8'h12);

    // Short low glitch must not produce a byte, and the receiver still works afterwards
    @(negedge clock);
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    rxd = 1'b1;
    repeat (30) @(negedge clock);
    peek(ST, s);
    chk("glitch_status", s, 8'h12);
    chk("glitch_irq", irq, 1'b0);
    send_rx(8'hA7, 1'b1);
    peek(ST, s);
    chk("post_glitch_status", s, 8'h13);
    peek(DT, s);
    chk("post_glitch_data", s, 8'hA7);
    bus_read(DT, s);

    // Randomized concurrent traffic against the register model
    m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_data = 8'hA7;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] btx, brx, wd;
      logic       stp;
      int         act;
      btx = 8'($urandom_range(0, 255));
      brx = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      act = $urandom_range(0, 2);
      fork
        tx_send_check(btx);
        send_rx(brx, stp);
      join
      model_frame(brx, stp);
      peek(ST, s);
      chk($sformatf("rand%0d_status", n), s, model_status());
      peek(DT, s);
      chk($sformatf("rand%0d_data", n), s, m_data);
      if (act == 1) begin
        bus_read(DT, s);
        m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      end else if (act == 2) begin
        wd = 8'($urandom_range(0, 255));
        bus_write(ST, wd);
        if (wd[7]) begin m_fe = 1'b0; m_ovr = 1'b0; end
      end
      peek(ST, s);
      chk($sformatf("rand%0d_after", n), s, model_status());
    end
    bus_read(DT, s);

    // Reset in the middle of both frames
    fork
      bus_write(DT, 8'h00);
      send_rx(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clock);
        #2;
        chk("txd_low_before_reset", txd, 1'b0);
        reset = 1'b1;
        #1;
        chk("txd_async_reset", txd, 1'b1);
        peek(ST, s2);
        chk("status_mid_reset", s2, 8'h12);
        chk("irq_mid_reset", irq, 1'b0);
        @(negedge clock);
        reset = 1'b0;
      end
    join
    peek(ST, s);
    chk("status_after_abort", s, 8'h12);
    chk("txd_after_abort", txd, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_console.md
MUX_CONSOLE -- requirements
Module: mux_console

Interface
REQ-001 The module SHALL have a parameter BASE_ADDR, default 16'hF200, giving the status register address; the data register is at BASE_ADDR+1.
REQ-002 The module SHALL have a parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit; it is even and at least 4.
REQ-003 The module SHALL have a port clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The module SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have a port addressBus, input, 16 bits: CPU memory address.
REQ-006 The module SHALL have a port dataOutBus, input, 8 bits: CPU write data.
REQ-007 The module SHALL have a port writeEnBus, input, 1 bit: CPU write strobe, sampled at the clock edge.
REQ-008 The module SHALL have a port readEnBus, input, 1 bit: CPU read strobe, used only for read side-effects.
REQ-009 The module SHALL have a port dataInBus, output, 8 bits: read data to the CPU.
REQ-010 The module SHALL have a port rxd, input, 1 bit: asynchronous serial receive line, idle high.
REQ-011 The module SHALL have a port txd, output, 1 bit: serial transmit line, idle high.
REQ-012 The module SHALL have a port irq, output, 1 bit: receive-ready interrupt request.

Function
REQ-013 The status byte SHALL be {3'b000, TX_IDLE, OVR, FE, TX_EMPTY, RX_RDY}, bits 7..0.
REQ-014 dataInBus SHALL be combinational: status when addressBus==BASE_ADDR, rx_data when addressBus==BASE_ADDR+1, otherwise 8'h00.
REQ-015 irq SHALL equal RX_RDY.
REQ-016 A write to BASE_ADDR+1 while TX_EMPTY=1 SHALL load the holding register and clear TX_EMPTY at that edge.
REQ-017 A write to BASE_ADDR+1 while TX_EMPTY=0 SHALL be discarded with no state change.
REQ-018 A write to BASE_ADDR with dataOutBus[7]=1 SHALL clear FE and OVR; other bits of that write SHALL be ignored.
REQ-019 A read strobe at BASE_ADDR+1 SHALL clear RX_RDY, FE and OVR at that edge.
REQ-020 The TX FSM SHALL have states IDLE, START, DATA and STOP.
REQ-021 TX: in IDLE with TX_EMPTY=0, the FSM SHALL move the holding register to the shifter, set TX_EMPTY=1 and TX_IDLE=0, and enter START, all in one cycle.
REQ-022 TX: START SHALL drive txd=0, DATA SHALL shift 8 bits LSB first, and STOP SHALL drive txd=1, each bit for exactly CLKS_PER_BIT cycles.
REQ-023 TX: after STOP, the FSM SHALL enter IDLE with TX_IDLE=1, or reload immediately (no extra idle bit) if the holding register is full.
REQ-024 rxd SHALL pass through a 2-flop synchroniser before use.
REQ-025 The RX FSM SHALL have states IDLE, START, DATA and STOP.
REQ-026 RX: in IDLE, a synchronised low SHALL enter START and zero the bit counter.
REQ-027 RX: at count CLKS_PER_BIT/2, START SHALL re-check the line; if high, the FSM SHALL return to IDLE as a glitch and load nothing.
REQ-028 RX: after a valid START, the FSM SHALL sample 8 data bits LSB first, then the stop bit, each CLKS_PER_BIT cycles after the previous sample.
REQ-029 RX: at the stop-bit sample, the module SHALL load rx_data, set RX_RDY=1, set FE=1 if the stop bit is 0, set OVR=1 if RX_RDY was already 1, and return to IDLE.
REQ-030 A new byte completing on the same edge as a data-register read SHALL take priority: RX_RDY stays 1, OVR is not set, and FE reflects the new byte.
REQ-031 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-032 While reset is high, the module SHALL hold txd=1, TX_EMPTY=1, TX_IDLE=1, RX_RDY=0, FE=0, OVR=0, rx_data=8'h00, and both FSMs in IDLE; status therefore reads 8'h12.
REQ-033 Reset asserted mid-frame SHALL abort both frames immediately, with txd returning high asynchronously.

Verification
REQ-034 The bench SHALL release reset and read address F200 -> dataInBus=8'h12, txd=1, irq=0.
REQ-035 The bench SHALL write 8'hA5 to F201 -> txd shows 0,1,0,1,0,0,1,0,1,1, each held 16 clocks; TX_EMPTY returns to 1 one cycle after the write.
REQ-036 The bench SHALL write 8'h41 then 8'h42 back-to-back, then 8'h43 while TX_EMPTY=0 -> exactly 8'h41 and 8'h42 are transmitted contiguously, and 8'h43 is dropped.
REQ-037 The bench SHALL drive rxd frame 8'h3C, read status, then read F201 -> status 8'h13, irq=1, data 8'h3C, and status 8'h12 after the read.
REQ-038 The bench SHALL receive two frames without a read, the second having stop bit 0 -> status 8'h1F and rx_data equal to the second byte; a write of 8'h80 to F200 then gives status 8'h13.
REQ-039 The bench SHALL apply a 4-cycle low glitch on rxd -> no RX_RDY, and the FSM is back in IDLE; reset asserted mid-TX-frame gives txd=1 immediately.
